// File: rtl/mul_ctrl_pkg.sv
// Shared encodings and helpers for the EX-stage multiply sequencing controller.
package mul_ctrl_pkg;

   localparam int unsigned DATA_BUS_WIDTH = 32;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      MUL_ST_IDLE = 2'b00,
      MUL_ST_CALC = 2'b01,
      MUL_ST_DONE = 2'b10
   } mul_st_e;

   // MUL and MULH share a mode so their products can be reused for each other
   typedef enum logic [1:0] {
      MUL_MODE_SS = 2'b00,
      MUL_MODE_SU = 2'b01,
      MUL_MODE_UU = 2'b10
   } mul_mode_e;

   function automatic mul_mode_e mode_of(input mul_op_e op);
      case (op)
         MUL_OP_MULHSU: mode_of = MUL_MODE_SU;
         MUL_OP_MULHU:  mode_of = MUL_MODE_UU;
         default:       mode_of = MUL_MODE_SS;
      endcase
   endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Pipeline-side request/response handshake of the multiply controller.
interface mul_ctrl_if
   import mul_ctrl_pkg::*;
#(
   parameter int unsigned DW = DATA_BUS_WIDTH
) ();

   logic          start_i;
   logic [1:0]    op_i;
   logic [DW-1:0] rs1_i;
   logic [DW-1:0] rs2_i;
   logic          ready_i;
   logic          busy_o;
   logic          valid_o;
   logic [DW-1:0] result_o;

   modport master (
      output start_i, op_i, rs1_i, rs2_i, ready_i,
      input  busy_o, valid_o, result_o
   );

   modport slave (
      input  start_i, op_i, rs1_i, rs2_i, ready_i,
      output busy_o, valid_o, result_o
   );

endinterface

// File: rtl/mul_abs.sv
// Conditional two's-complement magnitude of one multiplier operand.
module mul_abs
   import mul_ctrl_pkg::*;
#(
   parameter int unsigned DW = DATA_BUS_WIDTH
) (
   input  logic [DW-1:0] data,
   input  logic          sign_en,
   output logic [DW-1:0] abs_c
);

   // The most negative value maps to itself, which is its correct unsigned magnitude
   always_comb begin
      abs_c = data;
      if (sign_en && data[DW-1]) begin
         abs_c = ~data + DW'(1);
      end
   end

endmodule

// File: rtl/mul_ctrl.sv
// Sequences RV32M multiplies through an external combinational magnitude multiplier,
// with a one-entry product cache so MULH/MUL pairs on the same operands skip the multiply.
module mul_ctrl
   import mul_ctrl_pkg::*;
#(
   parameter int unsigned DW = DATA_BUS_WIDTH
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   mul_ctrl_if.slave       bus,
   output logic [DW-1:0]   mul_data1_o,
   output logic [DW-1:0]   mul_data2_o,
   output logic            mul_sign_o,
   input  logic [2*DW-1:0] mul_data_i
);

   mul_st_e       state_q, state_n;
   mul_op_e       op_q, op_n;
   mul_op_e       req_op;
   mul_mode_e     req_mode;
   logic [2*DW-1:0] product_q, product_n;
   logic [DW-1:0] result_q, result_n;
   logic          busy_q, valid_q;

   logic [DW-1:0] a_q, b_q;
   logic          neg_q;
   logic [DW-1:0] abs1_c, abs2_c;
   logic          s1, s2, neg_c;

   logic [DW-1:0] key_rs1_q, key_rs2_q;
   mul_mode_e     key_mode_q;
   logic [DW-1:0] cache_rs1_q, cache_rs2_q;
   mul_mode_e     cache_mode_q;
   logic [2*DW-1:0] cache_prod_q;
   logic          cache_vld_q;

   logic          hit_c, load_ops, cache_wr;

   // Request decode and operand preparation
   always_comb begin
      req_op   = mul_op_e'(bus.op_i);
      req_mode = mode_of(req_op);
      s1       = (req_mode != MUL_MODE_UU);
      s2       = (req_mode == MUL_MODE_SS);
      neg_c    = (s1 & bus.rs1_i[DW-1]) ^ (s2 & bus.rs2_i[DW-1]);
      hit_c    = cache_vld_q && (cache_rs1_q == bus.rs1_i) &&
                 (cache_rs2_q == bus.rs2_i) && (cache_mode_q == req_mode);
   end

   mul_abs #(.DW(DW)) u_abs1 (.data(bus.rs1_i), .sign_en(s1), .abs_c(abs1_c));
   mul_abs #(.DW(DW)) u_abs2 (.data(bus.rs2_i), .sign_en(s2), .abs_c(abs2_c));

   // Next-state and next-output logic
   always_comb begin
      state_n   = state_q;
      op_n      = op_q;
      product_n = product_q;
      load_ops  = 1'b0;
      cache_wr  = 1'b0;
      result_n  = '0;
      if (flush_i) begin
         state_n = MUL_ST_IDLE;
      end else begin
         case (state_q)
            MUL_ST_IDLE: begin
               if (bus.start_i) begin
                  op_n = req_op;
                  if (hit_c) begin
                     state_n   = MUL_ST_DONE;
                     product_n = cache_prod_q;
                  end else begin
                     state_n  = MUL_ST_CALC;
                     load_ops = 1'b1;
                  end
               end
            end
            MUL_ST_CALC: begin
               product_n = mul_data_i;
               cache_wr  = 1'b1;
               state_n   = MUL_ST_DONE;
            end
            MUL_ST_DONE: begin
               if (bus.ready_i) begin
                  state_n = MUL_ST_IDLE;
               end
            end
            default: state_n = MUL_ST_IDLE;
         endcase
      end
      if (state_n == MUL_ST_DONE) begin
         result_n = (op_n == MUL_OP_MUL) ? product_n[DW-1:0] : product_n[2*DW-1:DW];
      end
   end

   // State, datapath and cache registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= MUL_ST_IDLE;
         op_q         <= MUL_OP_MUL;
         product_q    <= '0;
         result_q     <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         neg_q        <= 1'b0;
         key_rs1_q    <= '0;
         key_rs2_q    <= '0;
         key_mode_q   <= MUL_MODE_SS;
         cache_rs1_q  <= '0;
         cache_rs2_q  <= '0;
         cache_mode_q <= MUL_MODE_SS;
         cache_prod_q <= '0;
         cache_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_n;
         op_q      <= op_n;
         product_q <= product_n;
         result_q  <= result_n;
         busy_q    <= (state_n != MUL_ST_IDLE);
         valid_q   <= (state_n == MUL_ST_DONE);
         if (load_ops) begin
            a_q        <= abs1_c;
            b_q        <= abs2_c;
            neg_q      <= neg_c;
            key_rs1_q  <= bus.rs1_i;
            key_rs2_q  <= bus.rs2_i;
            key_mode_q <= req_mode;
         end
         if (cache_wr) begin
            cache_rs1_q  <= key_rs1_q;
            cache_rs2_q  <= key_rs2_q;
            cache_mode_q <= key_mode_q;
            cache_prod_q <= mul_data_i;
            cache_vld_q  <= 1'b1;
         end
      end
   end

   assign bus.busy_o   = busy_q;
   assign bus.valid_o  = valid_q;
   assign bus.result_o = result_q;
   assign mul_data1_o  = a_q;
   assign mul_data2_o  = b_q;
   assign mul_sign_o   = neg_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Randomized and directed checks of mul_ctrl against an arithmetic reference with a cache model.
module tb_mul_ctrl;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush;
   logic [W-1:0]   d1, d2;
   logic           sgn;
   logic [2*W-1:0] mdata;
   logic [2*W-1:0] mag;

   int n_vec = 0;
   int n_err = 0;

   // Reference cache: last completed (non-flushed) computation
   bit          c_vld = 1'b0;
   logic [W-1:0] c_a, c_b;
   int          c_mode;

   mul_ctrl_if #(.DW(W)) bus ();

   mul_ctrl #(.DW(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .bus         (bus),
      .mul_data1_o (d1),
      .mul_data2_o (d2),
      .mul_sign_o  (sgn),
      .mul_data_i  (mdata)
   );

   always #5 clk = ~clk;

   // Stand-in for the external magnitude multiplier with post-negate
   assign mag   = {32'b0, d1} * {32'b0, d2};
   assign mdata = sgn ? (~mag + 64'd1) : mag;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int mode_num(input logic [1:0] op);
      return (op == 2'd3) ? 2 : (op == 2'd2) ? 1 : 0;
   endfunction

   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic signed [65:0] sa, sb, p;
      sa = (op == 2'd3) ? $signed({34'b0, a}) : $signed({{34{a[31]}}, a});
      sb = (op <= 2'd1) ? $signed({{34{b[31]}}, b}) : $signed({34'b0, b});
      p  = sa * sb;
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic bit ref_hit(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      return c_vld && (c_a == a) && (c_b == b) && (c_mode == mode_num(op));
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issue one request, check latency, result, backpressure hold and return to idle
   task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit poke, output logic [W-1:0] res);
      bit hit;
      int lat;
      logic [W-1:0] exp;
      hit = ref_hit(op, a, b);
      exp = ref_result(op, a, b);
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = op; bus.rs1_i = a; bus.rs2_i = b; bus.ready_i = 1'b0;
      @(negedge clk);
      bus.start_i = 1'b0;
      lat = 1;
      while (!bus.valid_o && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), hit ? 64'd1 : 64'd2);
      if (!hit) begin
         c_vld = 1'b1; c_a = a; c_b = b; c_mode = mode_num(op);
      end
      res = bus.result_o;
      check("result", 64'(bus.result_o), 64'(exp));
      check("busy_done", 64'(bus.busy_o), 64'd1);
      for (int i = 0; i < stall; i++) begin
         if (poke && i == 1) begin
            bus.start_i = 1'b1; bus.op_i = 2'd3; bus.rs1_i = ~a; bus.rs2_i = b ^ 32'h5;
         end else begin
            bus.start_i = 1'b0;
         end
         @(negedge clk);
         check("hold", {31'b0, bus.busy_o, bus.valid_o, bus.result_o}, {31'b0, 2'b11, exp});
      end
      bus.start_i = 1'b0;
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
      check("idle", {30'b0, bus.busy_o, bus.valid_o, bus.result_o}, 64'd0);
   endtask

   // Flush one cycle after issue: lands in CALC on a miss, DONE on a hit
   task automatic flush_early(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit hit;
      hit = ref_hit(op, a, b);
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = op; bus.rs1_i = a; bus.rs2_i = b; bus.ready_i = 1'b0;
      @(negedge clk);
      bus.start_i = 1'b0;
      check("fl_pre_valid", 64'(bus.valid_o), 64'(hit));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fl_idle", {30'b0, bus.busy_o, bus.valid_o, bus.result_o}, 64'd0);
      @(negedge clk);
      check("fl_no_pulse", {30'b0, bus.busy_o, bus.valid_o, bus.result_o}, 64'd0);
   endtask

   logic [W-1:0] res;
   logic [W-1:0] pa, pb;
   logic [1:0]   rop;
   int           lat;

   initial begin
      rst = 1'b1; flush = 1'b0;
      bus.start_i = 1'b0; bus.op_i = 2'd0; bus.rs1_i = '0; bus.rs2_i = '0; bus.ready_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out", {bus.busy_o, bus.valid_o, bus.result_o, sgn}, 35'd0);
      check("rst_mul", {d1, d2}, 64'd0);
      rst = 1'b0;

      do_op(2'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, res);
      check("mul_neg3", 64'(res), 64'hFFFF_FFEB);
      check("mul_drive", {31'b0, sgn, d2}, {31'b0, 1'b1, 32'd3});

      do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1, 0, res);
      check("mulh_min", 64'(res), 64'h4000_0000);
      do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, res);
      check("mulhu_max", 64'(res), 64'hFFFF_FFFE);
      do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, res);
      check("mulhsu_max", 64'(res), 64'hFFFF_FFFF);

      do_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, res);
      do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, res);
      check("mul_cached", 64'(res), 64'h242D_2080);
      do_op(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, res);

      // Backpressure with an ignored start pulse in DONE
      do_op(2'd0, 32'd1234, 32'd5678, 5, 1, res);

      // Flush in CALC, then the same request must miss
      flush_early(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      do_op(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, res);

      // Flush together with start in IDLE drops the request
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = 2'd0; bus.rs1_i = 32'd9; bus.rs2_i = 32'd9; flush = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0; flush = 1'b0;
      check("fl_start_drop", {30'b0, bus.busy_o, bus.valid_o, bus.result_o}, 64'd0);

      // Reset in DONE clears everything including the cache
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = 2'd0; bus.rs1_i = 32'hDEAD_BEEF; bus.rs2_i = 32'h0BAD_F00D;
      @(negedge clk);
      bus.start_i = 1'b0;
      lat = 1;
      while (!bus.valid_o && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("pre_rst_hit", 64'(lat), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_done_out", {bus.busy_o, bus.valid_o, bus.result_o, sgn}, 35'd0);
      check("rst_done_mul", {d1, d2}, 64'd0);
      c_vld = 1'b0;
      do_op(2'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, res);

      // Randomized traffic with operand reuse to exercise the cache
      pa = 32'd3; pb = 32'd5;
      for (int i = 0; i < 120; i++) begin
         logic [W-1:0] a, b;
         rop = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         if ($urandom_range(0, 2) == 0) begin
            a = pa; b = pb;
         end
         if ($urandom_range(0, 9) == 0) begin
            flush_early(rop, a, b);
         end else begin
            do_op(rop, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res);
         end
         pa = a; pb = b;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
